// File: rtl/imem_sync_fetch_if.sv
// Fetch-side request/response bundle for imem_sync_fetch.
// master = fetch stage, slave = instruction memory.
interface imem_sync_fetch_if #(
    parameter int unsigned WIDTH = 32
) ();
    logic             req_valid;
    logic             req_ready;
    logic [WIDTH-1:0] req_addr;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [WIDTH-1:0] rsp_data;
    logic             rsp_err;
    logic             rsp_perr;

    modport master (
        output req_valid, req_addr, rsp_ready,
        input  req_ready, rsp_valid, rsp_data, rsp_err, rsp_perr
    );

    modport slave (
        input  req_valid, req_addr, rsp_ready,
        output req_ready, rsp_valid, rsp_data, rsp_err, rsp_perr
    );
endinterface

// File: rtl/imem_sync_fetch.sv
// Synchronous instruction memory with a boot-stub init FSM, loader write port and a
// latency-1 valid/ready fetch path. Optional per-word even parity under IMEM_PARITY_EN.
module imem_sync_fetch #(
    parameter int unsigned WIDTH         = 32,
    parameter int unsigned ADDR_BITS     = 10,
    parameter int unsigned INST_POSITION = 10,
    parameter int unsigned SP_INIT       = 256,
    parameter int unsigned LR_INIT       = 1023
) (
    input  logic                    i_clk,
    input  logic                    i_reset,
    imem_sync_fetch_if.slave        fetch,
    input  logic                    i_ld_wr,
    input  logic [WIDTH-1:0]        i_ld_addr,
    input  logic [WIDTH-1:0]        i_ld_wdata,
    output logic                    o_init_done
);
    localparam int unsigned DEPTH   = 2 ** ADDR_BITS;
    localparam logic [11:0] SP_IMM  = 12'(SP_INIT);
    localparam logic [11:0] LR_IMM  = 12'(LR_INIT);
    // ADDI rd,x0,imm: imm | rs1=0 | funct3=0 | rd | OP-IMM
    localparam logic [31:0] BOOT_SP = {SP_IMM, 5'd0, 3'd0, 5'd2, 7'h13};
    localparam logic [31:0] BOOT_LR = {LR_IMM, 5'd0, 3'd0, 5'd1, 7'h13};
    localparam logic [31:0] NOP     = 32'h0000_0013;

    typedef enum logic {StInit, StReady} state_e;

    state_e                 r_state, w_state_d;
    logic [ADDR_BITS-1:0]   r_init_cnt, w_init_cnt_d;
    logic [WIDTH-1:0]       r_mem [DEPTH];
`ifdef IMEM_PARITY_EN
    logic                   r_par [DEPTH];
`endif
    logic                   r_rsp_valid;
    logic [WIDTH-1:0]       r_rsp_data;
    logic                   r_rsp_err;
    logic                   r_rsp_perr;

    logic                   w_req_ready, w_req_fire, w_req_err, w_ld_err, w_mem_we;
    logic                   w_rd_perr;
    logic [ADDR_BITS-1:0]   w_req_idx, w_ld_idx, w_mem_idx;
    logic [WIDTH-1:0]       w_boot_word, w_mem_wdata, w_rd_data;

    assign w_req_idx = fetch.req_addr[ADDR_BITS+1:2];
    assign w_ld_idx  = i_ld_addr[ADDR_BITS+1:2];
    assign w_req_err = (fetch.req_addr[1:0] != 2'b00) || ((fetch.req_addr >> (ADDR_BITS + 2)) != '0);
    assign w_ld_err  = (i_ld_addr[1:0] != 2'b00) || ((i_ld_addr >> (ADDR_BITS + 2)) != '0);

    always_comb begin
        w_boot_word = WIDTH'(NOP);
        if (r_init_cnt == '0) begin
            w_boot_word = WIDTH'(BOOT_SP);
        end else if (r_init_cnt == ADDR_BITS'(1)) begin
            w_boot_word = WIDTH'(BOOT_LR);
        end
    end

    always_comb begin
        w_state_d    = r_state;
        w_init_cnt_d = r_init_cnt;
        w_mem_we     = 1'b0;
        w_mem_idx    = w_ld_idx;
        w_mem_wdata  = i_ld_wdata;
        w_req_ready  = 1'b0;
        case (r_state)
            StInit: begin
                w_mem_we     = 1'b1;
                w_mem_idx    = r_init_cnt;
                w_mem_wdata  = w_boot_word;
                w_init_cnt_d = r_init_cnt + 1'b1;
                if (r_init_cnt == ADDR_BITS'(INST_POSITION - 1)) begin
                    w_state_d = StReady;
                end
            end
            StReady: begin
                // Loader write wins over fetch; a held response blocks new accepts.
                w_mem_we    = i_ld_wr & ~w_ld_err;
                w_req_ready = ~i_ld_wr & (~r_rsp_valid | fetch.rsp_ready);
            end
            default: w_state_d = StInit;
        endcase
        if (i_reset) begin
            w_mem_we = 1'b0;
        end
    end

    assign w_req_fire = fetch.req_valid & w_req_ready;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state    <= StInit;
            r_init_cnt <= '0;
        end else begin
            r_state    <= w_state_d;
            r_init_cnt <= w_init_cnt_d;
        end
    end

    // Array is deliberately not reset so user text survives a reset.
    always_ff @(posedge i_clk) begin
        if (w_mem_we) begin
            r_mem[w_mem_idx] <= w_mem_wdata;
`ifdef IMEM_PARITY_EN
            r_par[w_mem_idx] <= ^w_mem_wdata;
`endif
        end
    end

    assign w_rd_data = r_mem[w_req_idx];
`ifdef IMEM_PARITY_EN
    assign w_rd_perr = ^{r_mem[w_req_idx], r_par[w_req_idx]};
`else
    assign w_rd_perr = 1'b0;
`endif

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_rsp_valid <= 1'b0;
            r_rsp_data  <= '0;
            r_rsp_err   <= 1'b0;
            r_rsp_perr  <= 1'b0;
        end else if (w_req_fire) begin
            r_rsp_valid <= 1'b1;
            r_rsp_err   <= w_req_err;
            r_rsp_data  <= w_req_err ? WIDTH'(NOP) : w_rd_data;
            r_rsp_perr  <= w_req_err ? 1'b0 : w_rd_perr;
        end else if (fetch.rsp_ready) begin
            r_rsp_valid <= 1'b0;
        end
    end

    assign fetch.req_ready = w_req_ready;
    assign fetch.rsp_valid = r_rsp_valid;
    assign fetch.rsp_data  = r_rsp_data;
    assign fetch.rsp_err   = r_rsp_err;
    assign fetch.rsp_perr  = r_rsp_perr;
    assign o_init_done     = (r_state == StReady);
endmodule

// File: tb/tb_imem_sync_fetch.sv
// Self-checking bench for imem_sync_fetch: directed scenarios plus random traffic,
// every cycle compared against a transaction-level memory model.
module tb_imem_sync_fetch;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        reset, req_valid, rsp_ready, ld_wr;
    logic [31:0] req_addr, ld_addr, ld_wdata;
    logic        init_done;

    int n_total = 0;
    int n_bad   = 0;
    int n_acc   = 0;
    int n_con   = 0;

    // Reference model state
    logic [31:0] m_mem   [1024];
    bit          m_known [1024];
    bit          m_ready = 1'b0;
    int          m_cnt   = 0;
    bit          m_rsp_valid = 1'b0;
    logic [31:0] m_rsp_data;
    bit          m_rsp_err, m_rsp_known, m_fired;

    always #5 clk = ~clk;

    imem_sync_fetch_if #(.WIDTH(32)) bus ();
    assign bus.req_valid = req_valid;
    assign bus.req_addr  = req_addr;
    assign bus.rsp_ready = rsp_ready;

    imem_sync_fetch #(
        .WIDTH(32), .ADDR_BITS(10), .INST_POSITION(10), .SP_INIT(256), .LR_INIT(1023)
    ) dut (
        .i_clk       (clk),
        .i_reset     (reset),
        .fetch       (bus),
        .i_ld_wr     (ld_wr),
        .i_ld_addr   (ld_addr),
        .i_ld_wdata  (ld_wdata),
        .o_init_done (init_done)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit addr_bad(input logic [31:0] a);
        return (a % 4 != 0) || (a >= 32'd4096);
    endfunction

    // Compare at negedge, then advance the model across the next rising edge.
    task automatic tick();
        bit exp_rr;
        int idx;
        @(negedge clk);
        exp_rr = m_ready && !ld_wr && (!m_rsp_valid || rsp_ready);
        check_eq("init_done", 32'(init_done), 32'(m_ready));
        check_eq("req_ready", 32'(bus.req_ready), 32'(exp_rr));
        check_eq("rsp_valid", 32'(bus.rsp_valid), 32'(m_rsp_valid));
        if (m_rsp_valid) begin
            check_eq("rsp_err", 32'(bus.rsp_err), 32'(m_rsp_err));
            check_eq("rsp_perr", 32'(bus.rsp_perr), 32'd0);
            if (m_rsp_known) check_eq("rsp_data", bus.rsp_data, m_rsp_data);
        end
        m_fired = 1'b0;
        if (reset) begin
            m_ready = 1'b0;
            m_cnt = 0;
            m_rsp_valid = 1'b0;
            m_mem[0] = 32'h1000_0113;
            m_mem[1] = 32'h3FF0_0093;
            for (int i = 0; i < 10; i++) begin
                if (i >= 2) m_mem[i] = NOP;
                m_known[i] = 1'b1;
            end
        end else begin
            if (m_rsp_valid && rsp_ready) n_con++;
            if (exp_rr && req_valid) begin
                m_fired = 1'b1;
                n_acc++;
                m_rsp_valid = 1'b1;
                m_rsp_err = addr_bad(req_addr);
                idx = int'(req_addr / 4) % 1024;
                m_rsp_data = m_rsp_err ? NOP : m_mem[idx];
                m_rsp_known = m_rsp_err || m_known[idx];
            end else if (rsp_ready) begin
                m_rsp_valid = 1'b0;
            end
            if (m_ready && ld_wr && !addr_bad(ld_addr)) begin
                idx = int'(ld_addr / 4);
                m_mem[idx] = ld_wdata;
                m_known[idx] = 1'b1;
            end
            if (!m_ready) begin
                m_cnt++;
                if (m_cnt == 10) m_ready = 1'b1;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic fetch(input logic [31:0] a);
        int n = 0;
        req_valid = 1'b1;
        req_addr  = a;
        do begin
            tick();
            n++;
        end while (!m_fired && n < 40);
        req_valid = 1'b0;
        check_eq("fetch_rsp_valid", 32'(bus.rsp_valid), 32'd1);
    endtask

    task automatic load(input logic [31:0] a, input logic [31:0] d);
        ld_wr = 1'b1;
        ld_addr = a;
        ld_wdata = d;
        tick();
        ld_wr = 1'b0;
    endtask

    initial begin
        int n, acc0, con0;
        for (int i = 0; i < 1024; i++) m_known[i] = 1'b0;
        reset = 1'b1; req_valid = 1'b0; rsp_ready = 1'b1; ld_wr = 1'b0;
        req_addr = '0; ld_addr = '0; ld_wdata = '0;
        tick();
        reset = 1'b0;
        req_valid = 1'b1;
        req_addr = 32'h0;
        n = 0;
        while (!init_done && n < 40) begin
            tick();
            n++;
        end
        check_eq("init_latency", 32'(n), 32'd10);

        fetch(32'h0);
        check_eq("boot_sp", bus.rsp_data, 32'h1000_0113);
        fetch(32'h4);
        check_eq("boot_lr", bus.rsp_data, 32'h3FF0_0093);
        fetch(32'h24);
        check_eq("boot_nop", bus.rsp_data, NOP);

        load(32'h28, 32'h0010_0093);
        fetch(32'h28);
        check_eq("load_data", bus.rsp_data, 32'h0010_0093);
        check_eq("load_err", 32'(bus.rsp_err), 32'd0);

        // Streaming with a 3-cycle consumer stall on the second response
        load(32'h2C, 32'hA5A5_0113);
        load(32'h30, 32'h1234_5013);
        acc0 = n_acc;
        con0 = n_con;
        req_valid = 1'b1; req_addr = 32'h28;
        tick();
        req_addr = 32'h2C;
        tick();
        rsp_ready = 1'b0;
        req_addr = 32'h30;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_eq("stall_data", bus.rsp_data, 32'hA5A5_0113);
        end
        rsp_ready = 1'b1;
        tick();
        req_valid = 1'b0;
        tick();
        check_eq("stream_accepts", 32'(n_acc - acc0), 32'd3);
        check_eq("stream_consumed", 32'(n_con - con0), 32'd3);

        fetch(32'h2A);
        check_eq("misalign_err", 32'(bus.rsp_err), 32'd1);
        check_eq("misalign_data", bus.rsp_data, NOP);
        fetch(32'h1000);
        check_eq("range_err", 32'(bus.rsp_err), 32'd1);

        // Loader and fetch in the same cycle
        ld_wr = 1'b1; ld_addr = 32'h34; ld_wdata = 32'hCAFE_0137;
        req_valid = 1'b1; req_addr = 32'h34;
        tick();
        ld_wr = 1'b0;
        fetch(32'h34);
        check_eq("wr_then_rd", bus.rsp_data, 32'hCAFE_0137);

        // Reset with a pending response
        rsp_ready = 1'b0;
        req_valid = 1'b1; req_addr = 32'h28;
        tick();
        req_valid = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_eq("rst_drop", 32'(bus.rsp_valid), 32'd0);
        rsp_ready = 1'b1;
        fetch(32'h28);
        check_eq("user_preserved", bus.rsp_data, 32'h0010_0093);
        fetch(32'h0);
        check_eq("boot_rerun", bus.rsp_data, 32'h1000_0113);

        for (int c = 0; c < 800; c++) begin
            reset     = ($urandom_range(0, 99) == 0);
            req_valid = ($urandom_range(0, 2) != 0);
            rsp_ready = ($urandom_range(0, 3) != 0);
            ld_wr     = ($urandom_range(0, 3) == 0);
            req_addr  = 32'($urandom_range(0, 15)) * 4;
            if ($urandom_range(0, 7) == 0) req_addr = req_addr + 32'($urandom_range(1, 3));
            if ($urandom_range(0, 15) == 0) req_addr = req_addr | 32'h0000_1000;
            ld_addr   = 32'($urandom_range(0, 15)) * 4;
            if ($urandom_range(0, 7) == 0) ld_addr = ld_addr + 32'($urandom_range(1, 3));
            if ($urandom_range(0, 15) == 0) ld_addr = ld_addr | 32'h0001_0000;
            ld_wdata  = $urandom;
            tick();
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
